tv80_bus_bridge: RTL and testbench

//   Downstream of the negedge-strobed TV80 wrapper. Converts Z80 bus strobes (mreq_n/iorq_n/rd_n/wr_n)

---
 rtl/tv80_bus_bridge.sv | 197 +++++++++++++++++++
 tb/tb_tv80_bus_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv80_bus_bridge.sv
// tv80_bus_bridge
//   Turns TV80 (Z80-style) bus strobes into one outstanding req/ack transaction
//   for a memory/IO backend and returns read data to the CPU on di.
//   The CPU is stretched through wait_n until the access completes.
//   INTA cycles are answered locally with INT_VECTOR. Refresh cycles are ignored.
//   Optional watchdog: define TV80_BRIDGE_TIMEOUT_EN to force completion after TIMEOUT cycles.
module tv80_bus_bridge #(
  parameter int unsigned MIN_WAIT   = 2,
  parameter logic [7:0]  INT_VECTOR = 8'hFF,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        req,
  output logic        we,
  output logic        io,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic        ack,
  input  logic [7:0]  rdata,
  output logic        busy,
  output logic        err
);

  if (MIN_WAIT > 15 || TIMEOUT < 1) begin : g_param_check
    $error("tv80_bus_bridge: MIN_WAIT must be 0..15 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_INTA, S_DONE, S_HOLD} state_t;

  localparam logic [4:0] MIN_WAIT_W = 5'(MIN_WAIT);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic        done_q, done_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  di_q, di_d;
  logic [3:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic        strobe, inta, min_met;

  // A refresh cycle never counts as an access, even if a data strobe is low.
  assign strobe   = (~mreq_n | ~iorq_n) & (~rd_n | ~wr_n) & rfsh_n;
  assign inta     = ~m1_n & ~iorq_n;
  // Half-cycle path: strobes move on negedge, the CPU samples wait_n on posedge.
  assign wait_n   = ~((strobe | inta) & ~done_q);
  assign wcnt_inc = (wcnt_q == 4'd15) ? 4'd15 : wcnt_q + 4'd1;
  // True when the cycle now ending brings the access up to MIN_WAIT cycles.
  assign min_met  = ({1'b0, wcnt_q} + 5'd1) >= MIN_WAIT_W;

  assign req   = req_q;
  assign we    = we_q;
  assign io    = io_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign di    = di_q;
  assign busy  = (state_q != S_IDLE);

`ifdef TV80_BRIDGE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           err_q, err_d;
  logic           tmo;
  assign tmo = (tcnt_q == TCW'(TIMEOUT - 1));
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State and datapath registers; everything returns to its idle value on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      di_q    <= 8'hFF;
      wcnt_q  <= 4'd0;
`ifdef TV80_BRIDGE_TIMEOUT_EN
      tcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      io_q    <= io_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      di_q    <= di_d;
      wcnt_q  <= wcnt_d;
`ifdef TV80_BRIDGE_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: accept from IDLE, wait for ack or MIN_WAIT, hold done until strobes drop.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    io_d    = io_q;
    done_d  = done_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    di_d    = di_q;
    wcnt_d  = wcnt_q;
`ifdef TV80_BRIDGE_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (inta) begin
          wcnt_d  = 4'd0;
          state_d = S_INTA;
        end else if (strobe) begin
          addr_d  = A;
          wdata_d = cpu_do;
          we_d    = ~wr_n;
          io_d    = ~iorq_n;
          req_d   = 1'b1;
          wcnt_d  = 4'd0;
`ifdef TV80_BRIDGE_TIMEOUT_EN
          tcnt_d  = '0;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        wcnt_d = wcnt_inc;
`ifdef TV80_BRIDGE_TIMEOUT_EN
        tcnt_d = tcnt_q + TCW'(1);
`endif
        if (ack) begin
          req_d = 1'b0;
          if (!we_q) di_d = rdata;
          state_d = S_DONE;
        end
`ifdef TV80_BRIDGE_TIMEOUT_EN
        else if (tmo) begin
          req_d = 1'b0;
          if (!we_q) di_d = 8'hFF;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
        else if (!strobe) begin
          // CPU abandoned the access; a late ack will land in IDLE and be ignored.
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_INTA: begin
        wcnt_d = wcnt_inc;
        if (min_met) begin
          di_d    = INT_VECTOR;
          done_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_DONE: begin
        wcnt_d = wcnt_inc;
        if (min_met) begin
          done_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!strobe && !inta) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Scoreboard bench for tv80_bus_bridge: a CPU/backend driver pushes expected
// request fields and completion results into queues; a monitor pops and
// compares on every req rising edge and every busy falling edge.
module tb_tv80_bus_bridge;

  localparam int         MW = 2;
  localparam int         TO = 64;
  localparam logic [7:0] IV = 8'hC7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  cpu_do;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [7:0]  di;
  logic        wait_n, req, we, io;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy, err;

  int vectors     = 0;
  int miscompares = 0;

  // {we, io, addr, wdata} expected when req rises
  logic [25:0] exp_req_q[$];
  // {err, di} expected when busy falls
  logic [8:0]  exp_done_q[$];
  logic [7:0]  model_di;

  tv80_bus_bridge #(.MIN_WAIT(MW), .INT_VECTOR(IV), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .cpu_do(cpu_do), .m1_n(m1_n),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .di(di), .wait_n(wait_n), .req(req), .we(we), .io(io), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1; ack = 1'b0;
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 inta, 5 M1 opcode fetch
  task automatic access(input int kind, input logic [15:0] a, input logic [7:0] d,
                        input int k, input logic [7:0] rd);
    int  n, req_at, low;
    bit  fin, is_wr, is_io, is_inta;
    is_inta = (kind == 4);
    is_wr   = (kind == 1 || kind == 3);
    is_io   = (kind == 2 || kind == 3);
    if (!is_inta) exp_req_q.push_back({is_wr, is_io, a, d});
    @(negedge clk);
    A = a; cpu_do = d;
    m1_n   = !(is_inta || kind == 5);
    mreq_n = is_io || is_inta;
    iorq_n = !(is_io || is_inta);
    rd_n   = is_inta ? 1'($urandom_range(0, 1)) : is_wr;
    wr_n   = is_inta ? 1'b1 : !is_wr;
    req_at = -1; low = 0; fin = 0; n = 0;
    while (!fin && n < 300) begin
      if (n > 0) @(negedge clk);
      if (req_at < 0 && req) req_at = n;
      // CPU side wanders after the request; the bridge must hold its latched copy.
      if (req_at >= 0 && n > req_at) begin A = 16'($urandom); cpu_do = 8'($urandom); end
      ack   = (req_at >= 0 && n == req_at - 1 + k);
      rdata = ack ? rd : 8'($urandom);
      if (req_at >= 0 && n == req_at + k) begin
        chk("req_low_after_ack", 32'(req), 32'd0);
        if (!is_wr) chk("di_after_ack", 32'(di), 32'(rd));
      end
      #4;
      if (ack) begin
        chk("addr_held", 32'(addr), 32'(a));
        chk("wdata_held", 32'(wdata), 32'(d));
      end
      if (wait_n) fin = 1;
      else if (busy) low++;
      n++;
    end
    chk("wait_released", 32'(fin), 32'd1);
    if (is_inta) begin
      chk("inta_no_req", 32'(req_at >= 0), 32'd0);
      chk("inta_wait_cycles", 32'(low), 32'(imax(MW, 1)));
    end else begin
      chk("access_wait_cycles", 32'(low), 32'(imax(MW, k + 1)));
    end
    @(negedge clk);
    if (is_inta) model_di = IV;
    else if (!is_wr) model_di = rd;
    exp_done_q.push_back({1'b0, model_di});
    bus_idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic refresh(input int cycles, input logic rdv);
    @(negedge clk);
    rfsh_n = 1'b0; mreq_n = 1'b0; rd_n = rdv; A = 16'($urandom);
    for (int i = 0; i < cycles; i++) begin
      #4;
      chk("rfsh_wait_n", 32'(wait_n), 32'd1);
      chk("rfsh_busy", 32'(busy), 32'd0);
      chk("rfsh_req", 32'(req), 32'd0);
      @(negedge clk);
    end
    bus_idle();
  endtask

  task automatic start_read(input logic [15:0] a, input logic [7:0] d);
    int n;
    exp_req_q.push_back({1'b0, 1'b0, a, d});
    @(negedge clk);
    A = a; cpu_do = d; mreq_n = 1'b0; rd_n = 1'b0;
    n = 0;
    while (!req && n < 20) begin @(negedge clk); n++; end
    chk("read_req_seen", 32'(req), 32'd1);
  endtask

  // Monitor: compares request fields and completion results as they appear.
  initial begin : monitor
    logic        req_prev, busy_prev;
    logic [25:0] er;
    logic [8:0]  ed;
    req_prev = 1'b0; busy_prev = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (req && !req_prev) begin
        chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) begin
          er = exp_req_q.pop_front();
          chk("req_we", 32'(we), 32'(er[25]));
          chk("req_io", 32'(io), 32'(er[24]));
          chk("req_addr", 32'(addr), 32'(er[23:8]));
          chk("req_wdata", 32'(wdata), 32'(er[7:0]));
        end
      end
      if (busy_prev && !busy) begin
        chk("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
        if (exp_done_q.size() != 0) begin
          ed = exp_done_q.pop_front();
          chk("done_di", 32'(di), 32'(ed[7:0]));
          chk("done_err", 32'(err), 32'(ed[8]));
        end
      end
      req_prev  = req;
      busy_prev = busy;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int kind;
    reset_n = 1'b0; bus_idle(); A = 16'h0; cpu_do = 8'h0; rdata = 8'h0;
    model_di = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_io", 32'(io), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_di", 32'(di), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // IO write with immediate ack: di must stay at its reset value
    access(3, 16'h0010, 8'h3C, 1, 8'h00);
    // memory read, ack three cycles after req
    access(0, 16'h1234, 8'h00, 3, 8'hA5);
    // interrupt acknowledge
    access(4, 16'h0000, 8'h00, 1, 8'h00);
    // refresh, with and without a read strobe
    refresh(4, 1'b1);
    refresh(3, 1'b0);

    // abort: strobes drop before ack, then a late ack arrives in IDLE
    start_read(16'h4321, 8'h11);
    @(negedge clk);
    exp_done_q.push_back({1'b0, model_di});
    bus_idle();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(req), 32'd0);
    ack = 1'b1; rdata = 8'h99;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    chk("late_ack_di", 32'(di), 32'(model_di));
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_req", 32'(req), 32'd0);
    access(0, 16'h0001, 8'h00, 2, 8'h5A);

    // backend never answers
    start_read(16'hBEEF, 8'h22);
`ifdef TV80_BRIDGE_TIMEOUT_EN
    begin
      int t;
      t = 0;
      while (req && t < TO + 20) begin @(negedge clk); t++; end
      chk("timeout_req_drop_cycle", 32'(t), 32'(TO));
      t = 0;
      #4;
      while (!wait_n && t < 30) begin @(negedge clk); #4; t++; end
      chk("timeout_wait_n", 32'(wait_n), 32'd1);
      chk("timeout_di", 32'(di), 32'hFF);
      chk("timeout_err", 32'(err), 32'd1);
      @(negedge clk);
      model_di = 8'hFF;
      exp_done_q.push_back({1'b1, model_di});
      bus_idle();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("err_cleared", 32'(err), 32'd0);
      @(negedge clk);
    end
`else
    repeat (210) @(negedge clk);
    chk("no_timeout_req", 32'(req), 32'd1);
    chk("no_timeout_busy", 32'(busy), 32'd1);
    chk("no_timeout_err", 32'(err), 32'd0);
    #4;
    chk("no_timeout_wait_n", 32'(wait_n), 32'd0);
    @(negedge clk);
    exp_done_q.push_back({1'b0, model_di});
    bus_idle();
    @(negedge clk);
    chk("no_timeout_abort_req", 32'(req), 32'd0);
    @(negedge clk);
`endif

    // reset in the middle of an access
    start_read(16'h7777, 8'h33);
    @(negedge clk);
    model_di = 8'hFF;
    exp_done_q.push_back({1'b0, model_di});
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_di", 32'(di), 32'hFF);
    bus_idle();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // randomized mix
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 6));
      if (kind == 6) refresh(int'($urandom_range(2, 4)), 1'($urandom_range(0, 1)));
      else access(kind, 16'($urandom), 8'($urandom), int'($urandom_range(1, 5)), 8'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    chk("final_di", 32'(di), 32'(model_di));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
